// File: rtl/pipe_pkg.sv
// Shared constants and stage-control payload for the inter-stage register chain.
package pipe_pkg;

   // Default geometry of the 5-stage core's inter-stage registers
   localparam int unsigned PIPE_STAGES = 4;
   localparam int unsigned PIPE_DATA_W = 32;

   // Stage indices, youngest first
   localparam int unsigned STG_IFID  = 0;
   localparam int unsigned STG_IDEX  = 1;
   localparam int unsigned STG_EXMEM = 2;
   localparam int unsigned STG_MEMWB = 3;

   // Per-stage control resolved from the stall/flush OR-chains
   typedef struct packed {
      logic hold;
      logic kill;
   } stage_ctrl_t;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// One valid+payload pipeline register with kill/hold/bubble/load priority.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W    = PIPE_DATA_W,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  stage_ctrl_t       ctrl_i,
   input  logic              bubble_i,
   input  logic              load_valid_i,
   input  logic [DATA_W-1:0] load_data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;

   // Next state: kill beats hold, hold beats bubble, bubble beats load
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (ctrl_i.kill) begin
         valid_d = 1'b0;
      end else if (ctrl_i.hold) begin
         valid_d = valid_q;
      end else if (bubble_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = load_valid_i;
         // Payload only moves with a valid entry so bubbles leave data quiet
         if (load_valid_i) begin
            data_d = load_data_i;
         end
      end
   end

   // State register, asynchronously cleared
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         data_q  <= RESET_VAL;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule : pipe_stage_reg

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of inter-stage registers with stall, flush, bubbles and counters.
module pipe_stage_chain
   import pipe_pkg::*;
#(
   parameter int unsigned       NUM_STAGES = PIPE_STAGES,
   parameter int unsigned       DATA_W     = PIPE_DATA_W,
   parameter int unsigned       CNT_W      = 32,
   parameter logic [DATA_W-1:0] RESET_VAL  = '0
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_valid,
   input  logic [DATA_W-1:0]            i_data,
   input  logic [NUM_STAGES-1:0]        i_stall,
   input  logic [NUM_STAGES-1:0]        i_flush,
   output logic                         o_ready,
   output logic [NUM_STAGES-1:0]        o_valid,
   output logic [NUM_STAGES*DATA_W-1:0] o_data,
   output logic [CNT_W-1:0]             o_retire_cnt,
   output logic [CNT_W-1:0]             o_flush_cnt
);

   localparam int unsigned LAST = NUM_STAGES - 1;

   // Reject unsupported chain lengths at elaboration
   if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_num_stages
      $error("pipe_stage_chain: NUM_STAGES must be in 2..8");
   end

   logic [NUM_STAGES-1:0] hold_c;
   logic [NUM_STAGES-1:0] kill_c;
   logic [NUM_STAGES-1:0] valid_q;
   logic [DATA_W-1:0]     data_q [NUM_STAGES];
   logic [CNT_W-1:0]      retire_q, retire_d;
   logic [CNT_W-1:0]      flush_q,  flush_d;

   // Stall and flush propagate from each stage down to every younger stage
   always_comb begin
      hold_c       = '0;
      kill_c       = '0;
      hold_c[LAST] = i_stall[LAST];
      kill_c[LAST] = i_flush[LAST];
      for (int k = int'(LAST) - 1; k >= 0; k--) begin
         hold_c[k] = hold_c[k+1] | i_stall[k];
         kill_c[k] = kill_c[k+1] | i_flush[k];
      end
   end

   // Upstream may present a new entry only when stage 0 will take it
   assign o_ready = ~hold_c[0] & ~kill_c[0];

   for (genvar k = 0; k < int'(NUM_STAGES); k++) begin : g_stage
      stage_ctrl_t       ctrl_c;
      logic              bubble_c;
      logic              load_valid_c;
      logic [DATA_W-1:0] load_data_c;

      assign ctrl_c.hold = hold_c[k];
      assign ctrl_c.kill = kill_c[k];

      if (k == STG_IFID) begin : g_head
         // Youngest stage loads straight from the fetch side
         assign bubble_c     = 1'b0;
         assign load_valid_c = i_valid;
         assign load_data_c  = i_data;
      end else begin : g_body
         // A frozen predecessor leaves a bubble behind in this stage
         assign bubble_c     = hold_c[k-1];
         assign load_valid_c = valid_q[k-1];
         assign load_data_c  = data_q[k-1];
      end

      pipe_stage_reg #(
         .DATA_W    (DATA_W),
         .RESET_VAL (RESET_VAL)
      ) u_reg (
         .i_clk        (i_clk),
         .i_rst        (i_rst),
         .ctrl_i       (ctrl_c),
         .bubble_i     (bubble_c),
         .load_valid_i (load_valid_c),
         .load_data_i  (load_data_c),
         .valid_o      (valid_q[k]),
         .data_o       (data_q[k])
      );

      assign o_data[k*DATA_W +: DATA_W] = data_q[k];
   end

   assign o_valid = valid_q;

   // Counter next state: retire when the oldest entry leaves, count any flush cycle
   always_comb begin
      retire_d = retire_q;
      flush_d  = flush_q;
      if (valid_q[LAST] && !hold_c[LAST] && !kill_c[LAST]) begin
         retire_d = retire_q + CNT_W'(1);
      end
      if (|i_flush) begin
         flush_d = flush_q + CNT_W'(1);
      end
   end

   // Counter registers, free-running modulo 2^CNT_W
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         retire_q <= '0;
         flush_q  <= '0;
      end else begin
         retire_q <= retire_d;
         flush_q  <= flush_d;
      end
   end

   assign o_retire_cnt = retire_q;
   assign o_flush_cnt  = flush_q;

endmodule : pipe_stage_chain

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus random traffic against a reference model.
module tb_pipe_stage_chain;
   import pipe_pkg::*;

   localparam int          NS = 4;
   localparam int          DW = 32;
   localparam int          CW = 4;
   localparam logic [31:0] RV = 32'hDEAD_BEEF;

   logic             i_clk;
   logic             i_rst;
   logic             i_valid;
   logic [DW-1:0]    i_data;
   logic [NS-1:0]    i_stall;
   logic [NS-1:0]    i_flush;
   logic             o_ready;
   logic [NS-1:0]    o_valid;
   logic [NS*DW-1:0] o_data;
   logic [CW-1:0]    o_retire_cnt;
   logic [CW-1:0]    o_flush_cnt;

   pipe_stage_chain #(
      .NUM_STAGES (NS),
      .DATA_W     (DW),
      .CNT_W      (CW),
      .RESET_VAL  (RV)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .i_stall      (i_stall),
      .i_flush      (i_flush),
      .o_ready      (o_ready),
      .o_valid      (o_valid),
      .o_data       (o_data),
      .o_retire_cnt (o_retire_cnt),
      .o_flush_cnt  (o_flush_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: what each stage should hold, and event totals
   bit          m_valid [NS];
   logic [31:0] m_data  [NS];
   int          m_retire;
   int          m_flush;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NS; k++) begin
         m_valid[k] = 1'b0;
         m_data[k]  = RV;
      end
      m_retire = 0;
      m_flush  = 0;
   endtask

   task automatic check_state(input string tag);
      for (int k = 0; k < NS; k++) begin
         check_eq($sformatf("%s valid[%0d]", tag, k), o_valid[k], m_valid[k]);
         check_eq($sformatf("%s data[%0d]", tag, k), o_data[k*DW +: DW], m_data[k]);
      end
      check_eq({tag, " retire_cnt"}, o_retire_cnt, m_retire % 16);
      check_eq({tag, " flush_cnt"}, o_flush_cnt, m_flush % 16);
   endtask

   // One clock: drive, check current state, predict the next one, take the edge
   task automatic step(input logic v, input logic [31:0] d, input logic [NS-1:0] st,
                       input logic [NS-1:0] fl, output bit accepted);
      int          imax;
      int          jmax;
      bit          nv [NS];
      logic [31:0] nd [NS];
      i_valid = v;
      i_data  = d;
      i_stall = st;
      i_flush = fl;
      #1;
      // Youngest-to-oldest reach of the deepest flush and the deepest stall
      imax = -1;
      jmax = -1;
      for (int k = 0; k < NS; k++) begin
         if (fl[k]) imax = k;
         if (st[k]) jmax = k;
      end
      accepted = (imax < 0) && (jmax < 0);
      check_eq("ready", o_ready, accepted);
      check_state("state");
      for (int k = 0; k < NS; k++) begin
         nv[k] = m_valid[k];
         nd[k] = m_data[k];
         if (k <= imax) begin
            nv[k] = 1'b0;
         end else if (k <= jmax) begin
            nv[k] = m_valid[k];
         end else if (k == 0) begin
            nv[k] = v;
            if (v) nd[k] = d;
         end else if (k == jmax + 1) begin
            nv[k] = 1'b0;
         end else begin
            nv[k] = m_valid[k-1];
            if (m_valid[k-1]) nd[k] = m_data[k-1];
         end
      end
      if (m_valid[NS-1] && jmax < NS - 1 && imax < NS - 1) m_retire++;
      if (imax >= 0) m_flush++;
      @(posedge i_clk);
      for (int k = 0; k < NS; k++) begin
         m_valid[k] = nv[k];
         m_data[k]  = nd[k];
      end
      @(negedge i_clk);
   endtask

   // Asynchronous reset pulse starting mid-cycle, checked before any clock edge
   task automatic pulse_reset(input string tag);
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_stall = '0;
      i_flush = '0;
      #1;
      model_reset();
      check_state(tag);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      check_eq({tag, " ready after release"}, o_ready, 1'b1);
   endtask

   bit          acc;
   logic [31:0] nxt;
   logic [NS-1:0] st_r;
   logic [NS-1:0] fl_r;

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;
      i_stall = '0;
      i_flush = '0;
      model_reset();
      @(negedge i_clk);
      @(negedge i_clk);
      pulse_reset("por");
      @(negedge i_clk);

      // Back-to-back stream with no stalls
      step(1'b1, 32'h11, '0, '0, acc);
      step(1'b1, 32'h22, '0, '0, acc);
      step(1'b1, 32'h33, '0, '0, acc);
      step(1'b1, 32'h44, '0, '0, acc);
      check_eq("stream first at MEM/WB", {o_valid[STG_MEMWB], o_data[STG_MEMWB*DW +: DW]}, {1'b1, 32'h11});
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, '0, '0, acc);
      check_eq("stream last at MEM/WB", {o_valid[STG_MEMWB], o_data[STG_MEMWB*DW +: DW]}, {1'b1, 32'h44});
      step(1'b0, 32'h0, '0, '0, acc);
      check_eq("stream retire count", o_retire_cnt, 4'd4);

      // Stall at ID/EX for two cycles while upstream keeps offering
      nxt = 32'hA0;
      for (int i = 0; i < 10; i++) begin
         st_r = (i == 2 || i == 3) ? 4'b0010 : 4'b0000;
         step(1'b1, nxt, st_r, '0, acc);
         if (acc) nxt = nxt + 1;
      end
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, '0, '0, acc);

      // Flush and stall at the same stage, with an entry offered that cycle
      step(1'b1, 32'h51, '0, '0, acc);
      step(1'b1, 32'h52, '0, '0, acc);
      step(1'b1, 32'h77, 4'b0010, 4'b0010, acc);
      check_eq("flush cycle not accepted", acc, 1'b0);
      check_eq("flush valid[1:0]", o_valid[1:0], 2'b00);
      step(1'b0, 32'h0, '0, '0, acc);
      step(1'b0, 32'h0, '0, '0, acc);

      // Stall at MEM/WB freezes the whole chain
      step(1'b1, 32'h61, '0, '0, acc);
      step(1'b1, 32'h62, '0, '0, acc);
      step(1'b1, 32'h63, '0, '0, acc);
      step(1'b1, 32'h64, '0, '0, acc);
      for (int i = 0; i < 3; i++) step(1'b1, 32'h65, 4'b1000, '0, acc);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, '0, '0, acc);

      // Reset while three stages hold entries
      step(1'b1, 32'h81, '0, '0, acc);
      step(1'b1, 32'h82, '0, '0, acc);
      step(1'b1, 32'h83, '0, '0, acc);
      check_eq("pre-reset valid", o_valid, 4'b0111);
      pulse_reset("midrst");
      @(negedge i_clk);

      // Seventeen retirements wrap a 4-bit counter to one
      for (int i = 0; i < 17; i++) step(1'b1, 32'h100 + i, '0, '0, acc);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, '0, '0, acc);
      check_eq("retire wrap", o_retire_cnt, 4'd1);

      // Random traffic with sparse stalls and flushes
      for (int i = 0; i < 500; i++) begin
         st_r = '0;
         fl_r = '0;
         for (int k = 0; k < NS; k++) begin
            st_r[k] = ($urandom_range(0, 9) == 0);
            fl_r[k] = ($urandom_range(0, 19) == 0);
         end
         step($urandom_range(0, 3) != 0, $urandom, st_r, fl_r, acc);
      end
      step(1'b0, 32'h0, '0, '0, acc);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_pipe_stage_chain

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised replacement for the hand-written inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage core.
- Provides NUM_STAGES payload registers, each with a valid bit, and applies per-stage stall (backpressure), per-stage flush, and automatic bubble insertion.
- Also keeps retire and flush counters.
- All stages register on posedge i_clk.

Parameters:
- NUM_STAGES, 4, number of stage registers; index 0 is youngest (IF/ID), NUM_STAGES-1 is oldest (MEM/WB); legal range 2..8.
- DATA_W, 32, payload bits per stage.
- CNT_W, 32, width of the retire and flush counters.
- RESET_VAL, 0, payload value loaded on reset.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_valid  in  1  new entry valid at stage 0 input
- i_data  in  DATA_W  new entry payload
- i_stall  in  NUM_STAGES  bit k: stage k cannot advance this cycle
- i_flush  in  NUM_STAGES  bit k: discard stage k and all younger stages
- o_ready  out  1  stage 0 accepts i_data this cycle (upstream holds PC when 0)
- o_valid  out  NUM_STAGES  per-stage valid
- o_data  out  NUM_STAGES*DATA_W  per-stage payload; stage k at bits [k*DATA_W +: DATA_W]
- o_retire_cnt  out  CNT_W  entries that left the last stage
- o_flush_cnt  out  CNT_W  cycles with any flush asserted

Behaviour:
- Reset is asynchronous, active-high, reset i_rst; clock is i_clk. On reset:
  - o_valid = 0.
  - Every payload = RESET_VAL.
  - Both counters = 0.
  - o_ready = 1 once i_rst is released, provided no stall is asserted.
  - Reset mid-stream discards all entries immediately; there is no drain.
- Combinational terms:
  - hold[k] = OR of i_stall[NUM_STAGES-1:k]. A stalled stage freezes itself and every younger stage.
  - kill[k] = OR of i_flush[NUM_STAGES-1:k].
  - o_ready = ~hold[0] & ~kill[0].
- Per stage k, at each posedge, first matching rule wins:
  1. kill[k]: valid <= 0; payload unchanged. Flush wins over stall.
  2. hold[k]: valid and payload retained.
  3. k==0: valid <= i_valid; payload <= i_data only when i_valid=1.
  4. k>0 and hold[k-1]: bubble; valid <= 0; payload unchanged.
  5. Otherwise: valid <= valid[k-1]; payload <= payload[k-1] only when valid[k-1]=1.
- Rule 3 means an i_valid entry presented while o_ready=0 is not captured; upstream must re-present it.
- Payload loads only with valid=1, so bubbles do not toggle the data registers.
- Latency: an entry accepted at edge n appears at stage k after edge n+k, with no stalls.
- o_retire_cnt increments by 1 on an edge where valid[NUM_STAGES-1]=1 and i_stall[NUM_STAGES-1]=0 and i_flush[NUM_STAGES-1]=0.
- o_flush_cnt increments by 1 on an edge where |i_flush=1.
- Both counters wrap modulo 2^CNT_W; they have no saturation and no clear apart from reset.
- Simultaneous stall[j] and flush[i]:
  - Stages <= i are killed.
  - Stages i+1..j hold.
  - Stage j+1 takes a bubble.
- Outputs are registered state except o_ready, which is combinational from i_stall/i_flush.
- Elaboration check: NUM_STAGES < 2 or > 8 is an error.

Decomposition:
- pipe_pkg holds:
  - default constants (PIPE_STAGES=4, PIPE_DATA_W=32);
  - stage index localparams STG_IFID=0, STG_IDEX=1, STG_EXMEM=2, STG_MEMWB=3;
  - a stage_ctrl_t struct {hold, kill}.
- One sub-module, pipe_stage_reg, implements a single valid+payload register with hold/kill/load/bubble inputs and RESET_VAL.
- pipe_stage_chain generates NUM_STAGES instances of pipe_stage_reg and adds the hold/kill OR-chains and the counters.

Test Plan:
- Reset mid-stream (i_rst pulse with stages 0..2 valid) -> o_valid=4'b0000 immediately; payloads=RESET_VAL; counters=0; o_ready=1 after release.
- Stream 0x11,0x22,0x33,0x44 on consecutive cycles with no stall -> stage 3 shows 0x11 valid after edge 4, 0x44 after edge 7; o_retire_cnt=4 after edge 8.
- i_stall[1]=1 for 2 cycles while stream active -> stages 0,1 frozen; stage 2 valid=0 for 2 cycles; o_ready=0; no entry lost or duplicated after release.
- i_flush[1]=1 together with i_stall[1]=1 -> valid[1:0]=0 next edge; stage 2 takes a bubble; o_flush_cnt +1; an i_valid entry offered that cycle is not captured (o_ready=0).
- i_stall[3]=1 held 3 cycles -> all stages frozen; o_retire_cnt unchanged; resumes with +1 on the first edge after release.
- CNT_W=4, 17 retirements -> o_retire_cnt=1 (wrap-around).
